// File: rtl/lsu_apb.sv
// lsu_apb: RV32I load/store unit. Decodes each access to DMEM, the MMIO bank or an APB master.
// Loads return one cycle after acceptance; APB transfers stall the core until the slave completes.
// Optional ACCESS-phase timeout: define LSU_APB_TIMEOUT_EN.
module lsu_apb #(
   parameter int unsigned DMEM_WORDS  = 2048,
   parameter int unsigned NUM_HEX     = 8,
   parameter int unsigned LEDR_W      = 17,
   parameter int unsigned LEDG_W      = 8,
   parameter int unsigned SW_W        = 18,
   parameter int unsigned BTN_W       = 4,
   parameter int unsigned APB_NSLV    = 2,
   parameter int unsigned APB_AW      = 8,
   parameter int unsigned APB_TIMEOUT = 255
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [31:0]            i_lsu_addr,
   input  logic [31:0]            i_st_data,
   input  logic                   i_lsu_wren,
   input  logic                   i_lsu_rden,
   input  logic [2:0]             i_funct3,
   output logic [31:0]            o_ld_data,
   output logic                   o_ld_valid,
   output logic                   o_stall,
   output logic                   o_misaligned,
   output logic                   o_bus_err,
   input  logic [SW_W-1:0]        i_io_sw,
   input  logic [BTN_W-1:0]       i_io_btn,
   output logic [7*NUM_HEX-1:0]   o_io_hex,
   output logic [LEDR_W-1:0]      o_io_ledr,
   output logic [LEDG_W-1:0]      o_io_ledg,
   output logic [APB_NSLV-1:0]    o_psel,
   output logic                   o_penable,
   output logic                   o_pwrite,
   output logic [APB_AW-1:0]      o_paddr,
   output logic [31:0]            o_pwdata,
   input  logic [31:0]            i_prdata,
   input  logic                   i_pready,
   input  logic                   i_pslverr
);

   localparam int unsigned DmemAw = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} apb_st_e;

   apb_st_e                 state_q;
   logic [APB_NSLV-1:0]     psel_q, psel_d;
   logic                    penable_q, pwrite_q;
   logic [APB_AW-1:0]       paddr_q;
   logic [31:0]             pwdata_q;

   logic [31:0]             mem [DMEM_WORDS];
   logic [31:0]             dm_rdata_q;
   logic [LEDR_W-1:0]       ledr_q;
   logic [LEDG_W-1:0]       ledg_q;
   logic [7:0]              hex_q [16];

   logic                    ld_valid_q, misal_q, berr_q, ext_q, use_dm_q;
   logic [2:0]              f3_q;
   logic [1:0]              off_q;
   logic [31:0]             word_q, ld_word_d, mmio_word;

   logic req, is_st, sz_b, sz_h, sz_w, misal, slv_ok, apb_go, apb_done, timeout;
   logic stall, accept, wr_ok, rd_ok, berr_d;
   logic in_dm, in_ledr, in_ledg, in_hex, in_sw, in_btn, in_apb;
   logic [31:0] dm_off, wlane;
   logic [3:0]  be;
   logic [DmemAw-1:0] dm_idx;

   // Byte/half extraction with sign or zero extension.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
      logic [31:0] s;
      s = w >> {off, 3'b000};
      unique case (f3[1:0])
         2'b00:   extract = f3[2] ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
         2'b01:   extract = f3[2] ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default: extract = s;
      endcase
   endfunction

   // Request decode: size, alignment, target region.
   assign req     = i_lsu_wren | i_lsu_rden;
   assign is_st   = i_lsu_wren;
   assign sz_b    = (i_funct3[1:0] == 2'b00);
   assign sz_h    = (i_funct3[1:0] == 2'b01);
   assign sz_w    = ~sz_b & ~sz_h;
   assign dm_off  = i_lsu_addr - 32'h2000;
   assign dm_idx  = dm_off[DmemAw+1:2];
   assign in_dm   = (i_lsu_addr >= 32'h2000) && (dm_off < DMEM_WORDS * 4);
   assign in_ledr = (i_lsu_addr == 32'h7000);
   assign in_ledg = (i_lsu_addr == 32'h7010);
   assign in_hex  = (i_lsu_addr[31:4] == 28'h0000702);
   assign in_sw   = (i_lsu_addr == 32'h7800);
   assign in_btn  = (i_lsu_addr == 32'h7810);
   assign in_apb  = (i_lsu_addr[31:12] == 20'h00008);
   assign misal   = (sz_h & i_lsu_addr[0]) | (sz_w & (i_lsu_addr[1:0] != 2'b00)) |
                    (in_apb & ~sz_w);
   assign slv_ok  = ({28'd0, i_lsu_addr[11:8]} < APB_NSLV);
   assign apb_go  = req & in_apb & ~misal & slv_ok;
   assign apb_done = (state_q == StAccess) & (i_pready | timeout);

   // Only IDLE-with-request, SETUP and a waiting ACCESS hold the core; reset releases it at once.
   assign stall  = ~i_rst & (((state_q == StIdle) & apb_go) | (state_q == StSetup) |
                             ((state_q == StAccess) & ~i_pready & ~timeout));
   assign accept = req & ~stall;
   assign wr_ok  = accept & is_st & ~misal;
   assign rd_ok  = accept & ~is_st & ~misal;
   assign berr_d = (in_apb & ~misal & ~slv_ok) | (apb_done & (timeout | i_pslverr));

   // Byte enables and lane-aligned store data.
   always_comb begin
      be    = sz_b ? (4'b0001 << i_lsu_addr[1:0]) :
              sz_h ? (4'b0011 << i_lsu_addr[1:0]) : 4'b1111;
      wlane = i_st_data << {i_lsu_addr[1:0], 3'b000};
   end

   // MMIO read word; HEX bytes beyond NUM_HEX read as zero.
   always_comb begin
      mmio_word = '0;
      if (in_ledr)      mmio_word = 32'(ledr_q);
      else if (in_ledg) mmio_word = 32'(ledg_q);
      else if (in_sw)   mmio_word = 32'(i_io_sw);
      else if (in_btn)  mmio_word = 32'(i_io_btn);
      else if (in_hex) begin
         for (int j = 0; j < 4; j++) begin
            if ({28'd0, i_lsu_addr[3:2], 2'(j)} < NUM_HEX)
               mmio_word[8*j +: 8] = hex_q[{i_lsu_addr[3:2], 2'(j)}];
         end
      end
   end

   // Load word captured at acceptance (faults return zero, timeout returns a marker).
   always_comb begin
      ld_word_d = mmio_word;
      if (misal)         ld_word_d = '0;
      else if (apb_done) ld_word_d = timeout ? 32'hDEADBEEF : (i_pslverr ? '0 : i_prdata);
   end

   // DMEM: byte-enabled write and registered read, no reset.
   always_ff @(posedge i_clk) begin
      if (wr_ok && in_dm) begin
         for (int j = 0; j < 4; j++) begin
            if (be[j]) mem[dm_idx][8*j +: 8] <= wlane[8*j +: 8];
         end
      end
      if (rd_ok && in_dm) dm_rdata_q <= mem[dm_idx];
   end

   // MMIO output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ledr_q <= '0;
         ledg_q <= '0;
         for (int k = 0; k < 16; k++) hex_q[k] <= '0;
      end else if (wr_ok) begin
         if (in_ledr) ledr_q <= i_st_data[LEDR_W-1:0];
         if (in_ledg) ledg_q <= i_st_data[LEDG_W-1:0];
         if (in_hex) begin
            for (int j = 0; j < 4; j++) begin
               if (be[j] && ({28'd0, i_lsu_addr[3:2], 2'(j)} < NUM_HEX))
                  hex_q[{i_lsu_addr[3:2], 2'(j)}] <= wlane[8*j +: 8];
            end
         end
      end
   end

   // Load result and fault pulses, registered one cycle after acceptance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ld_valid_q <= 1'b0;
         misal_q    <= 1'b0;
         berr_q     <= 1'b0;
         ext_q      <= 1'b0;
         use_dm_q   <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         word_q     <= '0;
      end else begin
         ld_valid_q <= accept & ~is_st;
         misal_q    <= accept & misal;
         berr_q     <= accept & berr_d;
         if (accept) begin
            ext_q    <= ~misal & (in_dm | in_hex);
            use_dm_q <= ~misal & in_dm;
            f3_q     <= i_funct3;
            off_q    <= i_lsu_addr[1:0];
            word_q   <= ld_word_d;
         end
      end
   end

   // One-hot slave select from addr[11:8].
   always_comb begin
      psel_d = '0;
      for (int k = 0; k < APB_NSLV; k++) psel_d[k] = (i_lsu_addr[11:8] == 4'(k));
   end

   // APB master FSM with registered bus outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: if (apb_go) begin
               state_q  <= StSetup;
               psel_q   <= psel_d;
               paddr_q  <= i_lsu_addr[APB_AW-1:0];
               pwrite_q <= is_st;
               pwdata_q <= i_st_data;
            end
            StSetup: begin
               state_q   <= StAccess;
               penable_q <= 1'b1;
            end
            StAccess: if (i_pready || timeout) begin
               state_q   <= StIdle;
               psel_q    <= '0;
               penable_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef LSU_APB_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(APB_TIMEOUT + 1) > 8) ? $clog2(APB_TIMEOUT + 1) : 8;
   logic [CntW-1:0] to_cnt_q;

   // Count ACCESS cycles spent waiting for i_pready.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                   to_cnt_q <= '0;
      else if (state_q == StAccess && !i_pready)   to_cnt_q <= to_cnt_q + CntW'(1);
      else                                         to_cnt_q <= '0;
   end
   assign timeout = (state_q == StAccess) && !i_pready && (to_cnt_q == CntW'(APB_TIMEOUT - 1));
`else
   // No abort: ACCESS waits for i_pready indefinitely.
   assign timeout = (APB_TIMEOUT == 0) && 1'b0;
`endif

   // Output drive; HEX pins take bits [6:0] of each stored byte.
   always_comb begin
      o_io_hex = '0;
      for (int k = 0; k < NUM_HEX; k++) o_io_hex[7*k +: 7] = hex_q[k][6:0];
   end

   assign o_ld_valid   = ld_valid_q;
   assign o_ld_data    = ld_valid_q ? (ext_q ? extract(use_dm_q ? dm_rdata_q : word_q, f3_q, off_q)
                                             : word_q) : '0;
   assign o_misaligned = misal_q;
   assign o_bus_err    = berr_q;
   assign o_stall      = stall;
   assign o_io_ledr    = ledr_q;
   assign o_io_ledg    = ledg_q;
   assign o_psel       = psel_q;
   assign o_penable    = penable_q;
   assign o_pwrite     = pwrite_q;
   assign o_paddr      = paddr_q;
   assign o_pwdata     = pwdata_q;

endmodule
